// File: rtl/pdm_capture_controller.sv
// rtl/pdm_capture_controller.sv - PDM recording sequencer: deserializer gating, warm-up discard, sample RAM writes
module pdm_capture_controller #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int WARMUP_WORDS = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic                  deser_enable_o,
  input  logic                  word_done_i,
  input  logic [15:0]           word_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   sample_count_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(DEPTH - 1);
  localparam logic [15:0]   WARM_LAST = 16'(WARMUP_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, CAPTURE, FINISH} state_t;

  localparam state_t FIRST_STATE = (WARMUP_WORDS == 0) ? CAPTURE : WARMUP;

  state_t                state_q, state_d;
  logic                  en_q, en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [CW-1:0]         count_q, count_d;
  logic [15:0]           warm_q, warm_d;
  logic                  strobe;

  // The deserializer only produces meaningful strobes while it is enabled.
  assign strobe = word_done_i & en_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      count_q <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    warm_d  = warm_q;

    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (start_i) begin
          state_d = FIRST_STATE;
          en_d    = 1'b1;
          wcnt_d  = '0;
          warm_d  = '0;
          count_d = '0;
        end
      end
      WARMUP: begin
        if (stop_i) begin
          state_d = FINISH;
          en_d    = 1'b0;
          done_d  = 1'b1;
          count_d = wcnt_q;
        end else if (strobe) begin
          warm_d = warm_q + 16'd1;
          if (warm_q == WARM_LAST) state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (strobe) begin
          we_d   = 1'b1;
          addr_d = wcnt_q[ADDR_WIDTH-1:0];
          data_d = word_data_i;
          wcnt_d = wcnt_q + 1'b1;
          // Final address or a coincident stop: the write lands in FINISH.
          if (wcnt_q == LAST_WORD || stop_i) begin
            state_d = FINISH;
            en_d    = 1'b0;
            done_d  = 1'b1;
            count_d = wcnt_q + 1'b1;
          end
        end else if (stop_i) begin
          state_d = FINISH;
          en_d    = 1'b0;
          done_d  = 1'b1;
          count_d = wcnt_q;
        end
      end
      FINISH: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign deser_enable_o = en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_data_o     = data_q;
  assign sample_count_o = count_q;

endmodule
